mips_muldiv: RTL and testbench

MIPS_MULDIV -- requirements
Module: mips_muldiv

---
 rtl/mips_muldiv_if.sv | 26 ++
 rtl/mips_muldiv.sv | 148 ++++++++++++++
 tb/tb_mips_muldiv.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_if.sv
// Bus interface between the pipeline and the MIPS multiply/divide unit.
// The master side issues operations and HI/LO moves. The slave side (the unit) returns HI/LO and status.
interface mips_muldiv_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        signal_mthi;
    logic        signal_mtlo;
    logic [31:0] mt_data;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    modport master (
        output start, op, operand_a, operand_b, signal_mthi, signal_mtlo, mt_data,
        input  hi, lo, busy, done, div_by_zero
    );

    modport slave (
        input  start, op, operand_a, operand_b, signal_mthi, signal_mtlo, mt_data,
        output hi, lo, busy, done, div_by_zero
    );
endinterface

// File: rtl/mips_muldiv.sv
// MIPS HI/LO multiply/divide unit. It runs MULT, MULTU, DIV and DIVU iteratively, one bit per cycle.
// Multiply uses shift-add and divide uses restoring shift-subtract. Both work on operand magnitudes.
// A single sign-fix cycle corrects the result and writes it to HI/LO.
// op encoding: bit 1 selects divide, bit 0 selects unsigned.
module mips_muldiv (
    input  logic         clk,
    input  logic         rst,
    mips_muldiv_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t      r_state;
    logic [1:0]  r_op;
    logic        r_sign_a;
    logic        r_sign_b;
    logic        r_dbz;
    logic [31:0] r_operand;   // multiplicand magnitude or divisor magnitude
    logic [63:0] r_acc;       // mul: {partial product, multiplier}; div: {remainder, dividend/quotient}
    logic [5:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic        r_done;
    logic        r_div_by_zero;

    // Operand capture at acceptance. Only signed ops take magnitudes.
    logic        w_op_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_abs_a;
    logic [31:0] w_abs_b;
    logic        w_start_dbz;

    assign w_op_signed = ~bus.op[0];
    assign w_a_neg     = w_op_signed & bus.operand_a[31];
    assign w_b_neg     = w_op_signed & bus.operand_b[31];
    assign w_abs_a     = w_a_neg ? (32'd0 - bus.operand_a) : bus.operand_a;
    assign w_abs_b     = w_b_neg ? (32'd0 - bus.operand_b) : bus.operand_b;
    assign w_start_dbz = bus.op[1] & (bus.operand_b == 32'd0);

    // One shift-add multiply step. The 33-bit sum keeps the carry, which shifts into the top bit.
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_operand} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // One restoring divide step. Bring in the next dividend bit, then trial-subtract.
    // The quotient bit is 1 when no borrow occurs.
    logic [32:0] w_div_shift;
    logic [32:0] w_div_diff;
    logic [63:0] w_div_next;

    assign w_div_shift = {r_acc[63:32], r_acc[31]};
    assign w_div_diff  = w_div_shift - {1'b0, r_operand};
    assign w_div_next  = w_div_diff[32] ? {w_div_shift[31:0], r_acc[30:0], 1'b0}
                                        : {w_div_diff[31:0],  r_acc[30:0], 1'b1};

    // Sign correction. Sign bits are latched as 0 for unsigned ops, so no op check is needed here.
    // Quotient and product take sign_a ^ sign_b. The remainder takes sign_a (truncation toward zero).
    logic        w_neg_res;
    logic [63:0] w_product;
    logic [31:0] w_quot;
    logic [31:0] w_rem;

    assign w_neg_res = r_sign_a ^ r_sign_b;
    assign w_product = w_neg_res ? (64'd0 - r_acc) : r_acc;
    assign w_quot    = w_neg_res ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
    assign w_rem     = r_sign_a ? (32'd0 - r_acc[63:32]) : r_acc[63:32];

    // Control FSM with registered outputs: accept, iterate 32 times, then fix sign and write HI/LO.
    // NOTE: every register here uses non-blocking assignment, so all next-state terms read pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_op          <= 2'b00;
            r_sign_a      <= 1'b0;
            r_sign_b      <= 1'b0;
            r_dbz         <= 1'b0;
            r_operand     <= 32'd0;
            r_acc         <= 64'd0;
            r_cnt         <= 6'd0;
            r_hi          <= 32'd0;
            r_lo          <= 32'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
        end else begin
            r_done        <= 1'b0;
            r_div_by_zero <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        // start wins over a simultaneous HI/LO move
                        r_op      <= bus.op;
                        r_sign_a  <= w_a_neg;
                        r_sign_b  <= w_b_neg;
                        r_operand <= w_abs_b;
                        r_cnt     <= 6'd0;
                        r_busy    <= 1'b1;
                        r_dbz     <= w_start_dbz;
                        if (w_start_dbz) begin
                            // Divide by zero: the fixed result is staged now, and CALC is skipped.
                            r_acc   <= {bus.operand_a, 32'hFFFF_FFFF};
                            r_state <= S_FIX;
                        end else begin
                            r_acc   <= {32'd0, w_abs_a};
                            r_state <= S_CALC;
                        end
                    end else begin
                        if (bus.signal_mthi) r_hi <= bus.mt_data;
                        if (bus.signal_mtlo) r_lo <= bus.mt_data;
                    end
                end
                S_CALC: begin
                    r_acc <= r_op[1] ? w_div_next : w_mul_next;
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == 6'd31) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_dbz) begin
                        {r_hi, r_lo} <= r_acc;
                    end else if (r_op[1]) begin
                        r_hi <= w_rem;
                        r_lo <= w_quot;
                    end else begin
                        {r_hi, r_lo} <= w_product;
                    end
                    r_done        <= 1'b1;
                    r_div_by_zero <= r_dbz;
                    r_busy        <= 1'b0;
                    r_state       <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.hi          = r_hi;
    assign bus.lo          = r_lo;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.div_by_zero = r_div_by_zero;
endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv.
// Stimulus comes from a table of known vectors, randomized operations checked against an arithmetic model,
// and directed protocol and reset sequences.
module tb_mips_muldiv;
    logic clk;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    mips_muldiv_if bus();

    mips_muldiv dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Arithmetic reference: whole-number MIPS semantics using 64-bit integers
    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo, output logic dbz);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa  = $signed(a);
        sb  = $signed(b);
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        dbz = 1'b0;
        hi  = 32'd0;
        lo  = 32'd0;
        case (op)
            2'b00: begin p = sa * sb; {hi, lo} = p; end
            2'b01: begin p = ua * ub; {hi, lo} = p; end
            default: begin
                if (b == 32'd0) begin
                    dbz = 1'b1;
                    hi  = a;
                    lo  = 32'hFFFF_FFFF;
                end else if (op == 2'b10) begin
                    lo = 32'(sa / sb);
                    hi = 32'(sa % sb);
                end else begin
                    lo = a / b;
                    hi = a % b;
                end
            end
        endcase
    endfunction

    // Wait for done with a bound, sampling 1 time unit after each rising edge
    task automatic wait_done(inout int lat);
        while (!bus.done && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    // Issue one operation and wait for its result. Operands are scrambled while the operation runs.
    // proto_ok collects busy, HI/LO-hold and single-cycle-done behaviour.
    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi, output logic [31:0] lo, output logic dbz,
                         output int lat, output logic proto_ok);
        logic [31:0] hi0;
        logic [31:0] lo0;
        hi0 = bus.hi;
        lo0 = bus.lo;
        bus.start     = 1'b1;
        bus.op        = op;
        bus.operand_a = a;
        bus.operand_b = b;
        @(posedge clk); #1;
        bus.start = 1'b0;
        proto_ok  = 1'b1;
        lat       = 0;
        while (!bus.done && lat < 40) begin
            if (!bus.busy || bus.hi !== hi0 || bus.lo !== lo0) proto_ok = 1'b0;
            bus.operand_a = $urandom;
            bus.operand_b = $urandom;
            @(posedge clk); #1;
            lat++;
        end
        hi  = bus.hi;
        lo  = bus.lo;
        dbz = bus.div_by_zero;
        if (bus.busy) proto_ok = 1'b0;
        @(posedge clk); #1;
        if (bus.done || bus.div_by_zero) proto_ok = 1'b0;
    endtask

    initial begin
        vec_t        vecs[12];
        logic [31:0] hi, lo, mh, ml;
        logic        dbz, mdbz, ok;
        int          lat;

        vecs[0]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
        vecs[1]  = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
        vecs[2]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
        vecs[3]  = '{2'b11, 32'h0000_0064, 32'h0000_0000, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1};
        vecs[4]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
        vecs[5]  = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1};
        vecs[6]  = '{2'b11, 32'h0000_000A, 32'h0000_0003, 32'h0000_0001, 32'h0000_0003, 1'b0};
        vecs[7]  = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
        vecs[8]  = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
        vecs[9]  = '{2'b00, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0};
        vecs[10] = '{2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0};
        vecs[11] = '{2'b01, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};

        rst             = 1'b0;
        bus.start       = 1'b0;
        bus.op          = 2'b00;
        bus.operand_a   = 32'd0;
        bus.operand_b   = 32'd0;
        bus.signal_mthi = 1'b0;
        bus.signal_mtlo = 1'b0;
        bus.mt_data     = 32'd0;

        // Asynchronous reset takes effect before any clock edge
        #1 rst = 1'b1;
        #1;
        check("reset hi:lo", {bus.hi, bus.lo}, 64'd0);
        check("reset busy/done/dbz", {bus.busy, bus.done, bus.div_by_zero}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 12; i++) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, dbz, lat, ok);
            check($sformatf("vec%0d hi:lo", i), {hi, lo}, {vecs[i].hi, vecs[i].lo});
            check($sformatf("vec%0d div_by_zero", i), dbz, vecs[i].dbz);
            check($sformatf("vec%0d latency", i), lat, vecs[i].dbz ? 1 : 33);
            check($sformatf("vec%0d protocol", i), ok, 1'b1);
        end

        // Randomized operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            logic [1:0]  rop;
            logic [31:0] ra, rb;
            rop = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9)) | (rb & 32'h8000_0000);
            model(rop, ra, rb, mh, ml, mdbz);
            do_op(rop, ra, rb, hi, lo, dbz, lat, ok);
            check($sformatf("rnd%0d op%0d %h/%h hi:lo", i, rop, ra, rb), {hi, lo}, {mh, ml});
            check($sformatf("rnd%0d div_by_zero", i), dbz, mdbz);
            check($sformatf("rnd%0d latency", i), lat, mdbz ? 1 : 33);
            check($sformatf("rnd%0d protocol", i), ok, 1'b1);
        end

        // start and MTHI asserted mid-operation must both be ignored
        bus.start = 1'b1; bus.op = 2'b01; bus.operand_a = 32'd2; bus.operand_b = 32'd3;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        bus.start = 1'b1; bus.op = 2'b11; bus.operand_a = 32'd100; bus.operand_b = 32'd7;
        bus.signal_mthi = 1'b1; bus.mt_data = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.signal_mthi = 1'b0;
        lat = 5;
        wait_done(lat);
        check("busy-start latency", lat, 33);
        check("busy-start hi:lo", {bus.hi, bus.lo}, 64'd6);
        ok = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy) ok = 1'b0;
        end
        check("no queued op", ok, 1'b1);
        check("hi:lo stable after ignored op", {bus.hi, bus.lo}, 64'd6);

        // MTHI, then MTHI and MTLO together, while IDLE
        bus.signal_mthi = 1'b1; bus.mt_data = 32'h1234_5678;
        @(posedge clk); #1;
        bus.signal_mthi = 1'b0;
        check("mthi", {bus.hi, bus.lo}, {32'h1234_5678, 32'd6});
        bus.signal_mthi = 1'b1; bus.signal_mtlo = 1'b1; bus.mt_data = 32'hCAFE_F00D;
        @(posedge clk); #1;
        bus.signal_mthi = 1'b0; bus.signal_mtlo = 1'b0;
        check("mthi+mtlo", {bus.hi, bus.lo}, {32'hCAFE_F00D, 32'hCAFE_F00D});

        // start and MTHI on the same IDLE edge: start wins
        bus.start = 1'b1; bus.op = 2'b01; bus.operand_a = 32'd1; bus.operand_b = 32'd1;
        bus.signal_mthi = 1'b1; bus.mt_data = 32'hAAAA_5555;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.signal_mthi = 1'b0;
        check("start-wins hi held", bus.hi, 32'hCAFE_F00D);
        check("start-wins busy", bus.busy, 1'b1);
        lat = 0;
        wait_done(lat);
        check("start-wins hi:lo", {bus.hi, bus.lo}, 64'd1);

        // Reset in the middle of a DIV aborts it immediately, with no result and no done
        @(posedge clk); #1;
        bus.start = 1'b1; bus.op = 2'b10; bus.operand_a = 32'hFFFF_FFF9; bus.operand_b = 32'd2;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("mid-op reset busy", bus.busy, 1'b0);
        check("mid-op reset hi:lo", {bus.hi, bus.lo}, 64'd0);
        ok = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            if (bus.done || bus.busy || bus.hi != 32'd0 || bus.lo != 32'd0) ok = 1'b0;
        end
        check("held reset quiet", ok, 1'b1);

        // A start on the first edge after reset release runs normally
        @(negedge clk);
        rst = 1'b0;
        do_op(2'b11, 32'd10, 32'd3, hi, lo, dbz, lat, ok);
        check("post-reset divu hi:lo", {hi, lo}, {32'd1, 32'd3});
        check("post-reset latency", lat, 33);
        check("post-reset protocol", ok, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
